ray_scheduler: RTL and testbench

- Sequences the per-column ray-cast unit once per frame. It issues one ray request per screen column over a valid/ready handshake and limits the number of requests in flight.
- Collects the returned wall heights into a double-buffered column store.
- The pixel pipeline reads the front bank while the back bank fills. Banks swap only at frame start, and only after a complete frame has been rendered.
- Sits between the screen timing generator (frame_start pulse) and the ray-cast datapath; feeds the colour/paint stage.

---
 rtl/ray_scheduler_pkg.sv | 28 ++
 rtl/ray_scheduler_column_store.sv | 68 ++++++
 rtl/ray_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_ray_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ray_pkg
// Purpose  : Shared types and default constants for the ray scheduler and
//            its column store.
// Contents : state_t  - scheduler states (IDLE/ISSUE/DRAIN/DONE)
//            height_t - wall height at the default height width
//            H_RES_DEF, MAX_OUT_DEF, HW_DEF, CORDW_DEF - default sizes
// Revision : 1.0 - initial release
// ============================================================================
package ray_pkg;

  localparam int CORDW_DEF   = 10;
  localparam int H_RES_DEF   = 640;
  localparam int HW_DEF      = 9;
  localparam int MAX_OUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [HW_DEF-1:0] height_t;

endpackage
`default_nettype wire

// File: rtl/ray_scheduler_column_store.sv
`default_nettype none
// ============================================================================
// Module   : column_store
// Purpose  : Double-buffered per-column wall-height store. Two banks of
//            H_RES x HW simple dual-port RAM; the write port always targets
//            the back bank, the registered read port always the front bank,
//            so a read and a write never touch the same bank.
// Ports    : clk_in, rst_in (sync, active-low; clears only the read register)
//            front_sel_in            - bank currently displayed (0/1)
//            wr_en_in/wr_col_in/wr_data_in - back-bank write
//            rd_col_in/rd_data_out  - front-bank read, one-cycle latency,
//                                      out-of-range columns read as 0
// Revision : 1.0 - initial release
// ============================================================================
module column_store
  import ray_pkg::*;
#(
  parameter int CORDW = CORDW_DEF,
  parameter int H_RES = H_RES_DEF,
  parameter int HW    = HW_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             front_sel_in,
  input  logic             wr_en_in,
  input  logic [CORDW-1:0] wr_col_in,
  input  logic [HW-1:0]    wr_data_in,
  input  logic [CORDW-1:0] rd_col_in,
  output logic [HW-1:0]    rd_data_out
);

  localparam logic [CORDW:0] H_RES_C = (CORDW+1)'(H_RES);

  logic [HW-1:0] bank0_mem [H_RES];
  logic [HW-1:0] bank1_mem [H_RES];
  logic [HW-1:0] rd_data_q;
  logic          rd_in_range;

  assign rd_in_range = ({1'b0, rd_col_in} < H_RES_C);

  // Write port: the bank that is not being displayed.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      if (front_sel_in) begin
        bank0_mem[wr_col_in] <= wr_data_in;
      end else begin
        bank1_mem[wr_col_in] <= wr_data_in;
      end
    end
  end

  // Read port: RAM output register with synchronous clear.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_data_q <= '0;
    end else if (!rd_in_range) begin
      rd_data_q <= '0;
    end else if (front_sel_in) begin
      rd_data_q <= bank1_mem[rd_col_in];
    end else begin
      rd_data_q <= bank0_mem[rd_col_in];
    end
  end

  assign rd_data_out = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ray_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ray_scheduler
// Purpose  : Per-frame sequencer for the column ray-cast unit. Issues one
//            request per column over valid/ready with a cap on requests in
//            flight, collects returned heights into the back bank of a
//            double-buffered column store and swaps banks at frame start once
//            a complete frame has been rendered.
// Ports    : clk_in, rst_in (sync, active-low), frame_start_in
//            req_valid_out/req_ready_in/req_col_out - ray request handshake
//            res_valid_in/res_col_in/res_height_in  - ray results (no stall)
//            rd_col_in/rd_height_out                - front-bank read, 1 cycle
//            busy_out (ISSUE or DRAIN), frame_swap_out (bank swap pulse)
// Options  : RAYSCHED_STATS_EN adds drop_count_out[15:0] (frame starts seen
//            while rendering, saturating) and last_cycles_out[19:0] (cycles
//            from ISSUE entry to DONE entry for the latest frame).
// Revision : 1.0 - initial release
// ============================================================================
module ray_scheduler
  import ray_pkg::*;
#(
  parameter int CORDW   = CORDW_DEF,
  parameter int H_RES   = H_RES_DEF,
  parameter int HW      = HW_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start_in,
  output logic             req_valid_out,
  input  logic             req_ready_in,
  output logic [CORDW-1:0] req_col_out,
  input  logic             res_valid_in,
  input  logic [CORDW-1:0] res_col_in,
  input  logic [HW-1:0]    res_height_in,
  input  logic [CORDW-1:0] rd_col_in,
  output logic [HW-1:0]    rd_height_out,
  output logic             busy_out,
  output logic             frame_swap_out
`ifdef RAYSCHED_STATS_EN
  ,
  output logic [15:0]      drop_count_out,
  output logic [19:0]      last_cycles_out
`endif
);

  // Counters are one bit wider than a column so they can hold H_RES itself.
  localparam int             CNTW      = CORDW + 1;
  localparam logic [CNTW-1:0] H_RES_C  = CNTW'(H_RES);
  localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);
  localparam logic [3:0]      MAX_OUT_C = 4'(MAX_OUT);

  state_t           state_q, state_d;
  logic [CNTW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0]  ret_cnt_q, ret_cnt_d;
  logic [3:0]       outst_q, outst_d;
  logic             bank_q, bank_d;
  logic             req_valid_q, req_valid_d;
  logic [CORDW-1:0] req_col_q, req_col_d;
  logic             swap_q, swap_d;

  logic             hs;
  logic             busy;
  logic             res_ok;

  always_comb begin
    hs     = req_valid_q && req_ready_in;
    busy   = (state_q == ISSUE) || (state_q == DRAIN);
    // Results are only meaningful while a render is in progress.
    res_ok = res_valid_in && busy && ({1'b0, res_col_in} < H_RES_C);

    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    outst_d     = outst_q;
    bank_d      = bank_q;
    swap_d      = 1'b0;

    if (hs) begin
      issue_cnt_d = issue_cnt_q + ONE_C;
    end
    if (res_ok) begin
      ret_cnt_d = ret_cnt_q + ONE_C;
    end
    // Simultaneous issue and return cancel out.
    if (hs && !res_ok) begin
      outst_d = outst_q + 4'd1;
    end else if (!hs && res_ok) begin
      outst_d = outst_q - 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          outst_d     = '0;
        end
      end
      ISSUE: begin
        if (hs && (issue_cnt_q == H_RES_C - ONE_C)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ret_cnt_q >= H_RES_C) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (frame_start_in) begin
          state_d     = ISSUE;
          bank_d      = ~bank_q;
          swap_d      = 1'b1;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          outst_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request outputs are registered, so they are computed from next-state
    // values; this keeps them stable while valid is held against !ready.
    req_valid_d = (state_d == ISSUE) && (outst_d < MAX_OUT_C) &&
                  (issue_cnt_d < H_RES_C);
    req_col_d   = issue_cnt_d[CORDW-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
      bank_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_col_q   <= '0;
      swap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      outst_q     <= outst_d;
      bank_q      <= bank_d;
      req_valid_q <= req_valid_d;
      req_col_q   <= req_col_d;
      swap_q      <= swap_d;
    end
  end

  assign req_valid_out  = req_valid_q;
  assign req_col_out    = req_col_q;
  assign busy_out       = busy;
  assign frame_swap_out = swap_q;

  column_store #(
    .CORDW (CORDW),
    .H_RES (H_RES),
    .HW    (HW)
  ) u_column_store (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .front_sel_in (bank_q),
    .wr_en_in     (res_ok),
    .wr_col_in    (res_col_in),
    .wr_data_in   (res_height_in),
    .rd_col_in    (rd_col_in),
    .rd_data_out  (rd_height_out)
  );

`ifdef RAYSCHED_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [19:0] cyc_q, cyc_d;
  logic [19:0] last_q, last_d;

  always_comb begin
    drop_d = drop_q;
    cyc_d  = cyc_q;
    last_d = last_q;
    if (frame_start_in && busy && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    // cyc_q counts edges since ISSUE entry; DONE entry records cyc_q + 1.
    if ((state_q != ISSUE) && (state_d == ISSUE)) begin
      cyc_d = '0;
    end else if (busy && (cyc_q != 20'hFFFFF)) begin
      cyc_d = cyc_q + 20'd1;
    end
    if ((state_q == DRAIN) && (state_d == DONE)) begin
      last_d = (cyc_q == 20'hFFFFF) ? cyc_q : cyc_q + 20'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      drop_q <= '0;
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      drop_q <= drop_d;
      cyc_q  <= cyc_d;
      last_q <= last_d;
    end
  end

  assign drop_count_out  = drop_q;
  assign last_cycles_out = last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ray_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ray_scheduler
// Purpose  : Self-checking bench for ray_scheduler. A small ray-cast model
//            answers each accepted request three cycles later; read-back of
//            the front bank uses a table of {column, expected height}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       frame_start_in;
  logic       req_valid_out;
  logic       req_ready_in;
  logic [9:0] req_col_out;
  logic       res_valid_in;
  logic [9:0] res_col_in;
  logic [8:0] res_height_in;
  logic [9:0] rd_col_in;
  logic [8:0] rd_height_out;
  logic       busy_out;
  logic       frame_swap_out;
`ifdef RAYSCHED_STATS_EN
  logic [15:0] drop_count_out;
  logic [19:0] last_cycles_out;
`endif

  always #5 clk_in = ~clk_in;

  ray_scheduler dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .req_valid_out  (req_valid_out),
    .req_ready_in   (req_ready_in),
    .req_col_out    (req_col_out),
    .res_valid_in   (res_valid_in),
    .res_col_in     (res_col_in),
    .res_height_in  (res_height_in),
    .rd_col_in      (rd_col_in),
    .rd_height_out  (rd_height_out),
    .busy_out       (busy_out),
    .frame_swap_out (frame_swap_out)
`ifdef RAYSCHED_STATS_EN
    ,
    .drop_count_out (drop_count_out),
    .last_cycles_out(last_cycles_out)
`endif
  );

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] h;
    int         due;
  } pend_t;

  typedef struct {
    logic [9:0] col;
    logic [8:0] exp_h;
  } rd_vec_t;

  pend_t   q[$];
  rd_vec_t rtab[8];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fsel = 0;
  bit ret_en = 1'b1;
  bit man_v = 1'b0;
  logic [9:0] man_col;
  logic [8:0] man_h;
  int issued = 0, exp_col = 0, order_err = 0;
  int outst_m = 0, max_outst = 0, swap_seen = 0;

  function automatic logic [8:0] hgen(logic [9:0] c, int f);
    int ci, v;
    ci = int'(c);
    v  = (f == 0) ? (ci % 256) : ((ci * 3 + 7) % 512);
    return v[8:0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: account for the handshake/result the DUT sees at this edge,
  // then drive the next result from the model queue.
  task automatic step();
    bit    hs;
    pend_t r;
    hs = (req_valid_out === 1'b1) && (req_ready_in === 1'b1);
    if (res_valid_in && (res_col_in < 10'd640) && busy_out) outst_m--;
    if (hs) begin
      issued++;
      if (int'(req_col_out) != exp_col) order_err++;
      exp_col++;
      outst_m++;
      q.push_back('{req_col_out, hgen(req_col_out, fsel), cyc + 3});
    end
    if (outst_m > max_outst) max_outst = outst_m;
    if (frame_swap_out) swap_seen++;
    @(posedge clk_in);
    #1;
    cyc++;
    if (man_v) begin
      res_valid_in  = 1'b1;
      res_col_in    = man_col;
      res_height_in = man_h;
      man_v         = 1'b0;
    end else if (ret_en && (q.size() > 0) && (q[0].due <= cyc)) begin
      r = q.pop_front();
      res_valid_in  = 1'b1;
      res_col_in    = r.col;
      res_height_in = r.h;
    end else begin
      res_valid_in  = 1'b0;
    end
  endtask

  task automatic fs_pulse(bit new_frame);
    frame_start_in = 1'b1;
    if (new_frame) begin
      issued  = 0;
      exp_col = 0;
    end
    step();
    frame_start_in = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (busy_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(name, ok, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_valid"}, req_valid_out, 0);
    check({tag, "_req_col"}, req_col_out, 0);
    check({tag, "_rd_height"}, rd_height_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_swap"}, frame_swap_out, 0);
  endtask

  initial begin
    int  stall_err;
    bit  ok;

    rtab[0] = '{10'd1,    9'd1};
    rtab[1] = '{10'd5,    9'd5};    // also written while DONE: must stay 5
    rtab[2] = '{10'd10,   9'd10};
    rtab[3] = '{10'd255,  9'd255};
    rtab[4] = '{10'd300,  9'd44};
    rtab[5] = '{10'd639,  9'd127};
    rtab[6] = '{10'd640,  9'd0};
    rtab[7] = '{10'd1023, 9'd0};

    rst_in = 1'b0; frame_start_in = 1'b0; req_ready_in = 1'b0;
    res_valid_in = 1'b0; res_col_in = '0; res_height_in = '0; rd_col_in = '0;
    man_col = '0; man_h = '0;
    step(); step();
    check_reset_outputs("rst");
    rst_in = 1'b1;
    step();
    check("idle_no_valid", req_valid_out, 0);

    // Frame 1: full render with heights col%256.
    req_ready_in = 1'b1; fsel = 0; ret_en = 1'b1;
    fs_pulse(1'b1);
    check("f1_start_valid", req_valid_out, 1);
    check("f1_start_col", req_col_out, 0);
    check("f1_start_busy", busy_out, 1);
    swap_seen = 0; max_outst = 0;
    wait_idle("f1_done_timeout");
    check("f1_issued", issued, 640);
    check("f1_order_errors", order_err, 0);
    check("f1_max_outst_le4", (max_outst <= 4), 1);
    check("f1_no_swap", swap_seen, 0);

    // Result while DONE must be ignored.
    man_v = 1'b1; man_col = 10'd5; man_h = 9'h1FF;
    step(); step();
    check("done_res_still_done", busy_out, 0);

    // Frame 2: swap, hold ready low while reading front bank.
    req_ready_in = 1'b0; fsel = 1;
    fs_pulse(1'b1);
    check("f2_swap_pulse", frame_swap_out, 1);
    step();
    check("f2_swap_one_cycle", frame_swap_out, 0);
    for (int i = 0; i < 8; i++) begin
      rd_col_in = rtab[i].col;
      step();
      check($sformatf("rd_col_%0d", rtab[i].col), rd_height_out, rtab[i].exp_h);
    end
    stall_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid_out !== 1'b1 || req_col_out !== 10'd0) stall_err++;
      step();
    end
    check("stall_stable", stall_err, 0);
    check("stall_none_issued", issued, 0);

    // Release ready; drop a frame start during DRAIN.
    req_ready_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (issued == 640) begin ok = 1'b1; break; end
      step();
    end
    check("f2_issue_timeout", ok, 1);
    swap_seen = 0;
    fs_pulse(1'b0);
    check("drain_fs_no_swap", frame_swap_out, 0);
    check("drain_fs_still_busy", busy_out, 1);
    wait_idle("f2_done_timeout");
    check("f2_no_swap", swap_seen, 0);
    rd_col_in = 10'd10;
    step();
    check("drop_front_unchanged", rd_height_out, 10);
`ifdef RAYSCHED_STATS_EN
    check("drop_count", drop_count_out, 1);
`endif

    // Frame 3: swap timing, then ray unit stops answering.
    ret_en = 1'b0; fsel = 0;
    fs_pulse(1'b1);
    check("f3_swap_pulse", frame_swap_out, 1);
    check("f3_swap_cycle_old", rd_height_out, 10);
    step();
    check("f3_after_swap_new", rd_height_out, 37);
    for (int i = 0; i < 20; i++) step();
    check("noret_issued", issued, 4);
    check("noret_valid_low", req_valid_out, 0);
    man_v = 1'b1; man_col = 10'd700; man_h = 9'd1;
    step(); step(); step();
    check("col700_valid_low", req_valid_out, 0);
    check("col700_issued", issued, 4);
    ret_en = 1'b1;
    wait_idle("f3_done_timeout");
    check("f3_issued", issued, 640);
    check("f3_order_errors", order_err, 0);

    // Frame 4: reset at column 300.
    fs_pulse(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (req_col_out == 10'd300) begin ok = 1'b1; break; end
      step();
    end
    check("col300_timeout", ok, 1);
    rst_in = 1'b0;
    step();
    q.delete(); outst_m = 0;
    check_reset_outputs("midrst");
    rst_in = 1'b1;
    man_v = 1'b1; man_col = 10'd3; man_h = 9'd5;
    step(); step();
    check("late_res_idle_busy", busy_out, 0);
    check("late_res_idle_valid", req_valid_out, 0);
    fs_pulse(1'b1);
    check("restart_valid", req_valid_out, 1);
    check("restart_col", req_col_out, 0);
    wait_idle("f5_done_timeout");
    check("f5_issued", issued, 640);
    check("f5_order_errors", order_err, 0);
    check("all_max_outst_le4", (max_outst <= 4), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
